// File: rtl/loader_port_sched.sv
// SDRAM port-A arbiter: buffers ROM-loader bytes in a small FIFO, issues them one per
// nes_ce slot, and keeps the NES CPU held until every byte is committed plus a guard time.
module loader_port_sched #(
  parameter int         ADDR_W      = 22,
  parameter int         FIFO_LG2    = 2,
  parameter logic [1:0] SLOT_PHASE  = 2'd1,
  parameter int         HOLD_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        nes_ce_i,
  input  logic              downloading_i,
  input  logic              ldr_wr_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [7:0]        ldr_data_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [7:0]        cpu_dout_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic              mem_oe_o,
  output logic [7:0]        mem_din_o,
  output logic              cpu_hold_o,
  output logic              ldr_overflow_o,
  output logic [FIFO_LG2:0] fifo_level_o
);

  localparam int DEPTH = 1 << FIFO_LG2;
  localparam int LVL_W = FIFO_LG2 + 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {ST_BOOT, ST_LOAD, ST_DRAIN, ST_HOLD, ST_IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fifo_addr_q [DEPTH];
  logic [7:0]          fifo_data_q [DEPTH];
  logic [FIFO_LG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
  logic [7:0]          ld_data_q, ld_data_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                ovf_q, ovf_d;
  logic                dl_q;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;

  logic slot, issuing_st, accept_st, pop, push, drop, dl_rise;

  always_comb begin
    slot       = (nes_ce_i == SLOT_PHASE);
    issuing_st = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    accept_st  = issuing_st || (state_q == ST_HOLD);
    pop        = issuing_st && slot && (level_q != '0);
    // A full FIFO still takes a byte when the head leaves on the same clk.
    push       = ldr_wr_i && accept_st && ((level_q != LVL_W'(DEPTH)) || pop);
    drop       = ldr_wr_i && accept_st && !push;
    dl_rise    = downloading_i && !dl_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  if (downloading_i) state_d = ST_LOAD;
      ST_LOAD:  if (!downloading_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (downloading_i)                       state_d = ST_LOAD;
        else if ((level_q == '0) && !mem_we_q)   state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (downloading_i)          state_d = ST_LOAD;
        else if (hold_cnt_q == '0)  state_d = ST_IDLE;
      end
      ST_IDLE:  if (downloading_i) state_d = ST_LOAD;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((state_d == ST_HOLD) && (state_q != ST_HOLD))
      hold_cnt_d = HOLD_INIT;
    else if ((state_q == ST_HOLD) && (hold_cnt_q != '0))
      hold_cnt_d = hold_cnt_q - CNT_W'(1);

    wr_ptr_d = push ? wr_ptr_q + FIFO_LG2'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_LG2'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    // Each write occupies exactly one slot: reload or release only on a slot clk.
    mem_we_d  = mem_we_q;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    if (pop) begin
      mem_we_d  = 1'b1;
      ld_addr_d = fifo_addr_q[rd_ptr_q];
      ld_data_d = fifo_data_q[rd_ptr_q];
    end else if (slot) begin
      mem_we_d  = 1'b0;
    end

    ovf_d      = (dl_rise ? 1'b0 : ovf_q) | drop;
    cpu_hold_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_BOOT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      mem_we_q   <= 1'b0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      ovf_q      <= 1'b0;
      dl_q       <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      mem_we_q   <= mem_we_d;
      ld_addr_q  <= ld_addr_d;
      ld_data_q  <= ld_data_d;
      cpu_hold_q <= cpu_hold_d;
      ovf_q      <= ovf_d;
      dl_q       <= downloading_i;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Storage is not reset; a flush only needs the pointers and level cleared.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= ldr_addr_i;
      fifo_data_q[wr_ptr_q] <= ldr_data_i;
    end
  end

  always_comb begin
    if (state_q == ST_IDLE) begin
      mem_addr_o = cpu_addr_i;
      mem_we_o   = cpu_write_i;
      mem_oe_o   = cpu_read_i;
      mem_din_o  = cpu_dout_i;
    end else begin
      mem_addr_o = ld_addr_q;
      mem_we_o   = mem_we_q;
      mem_oe_o   = 1'b0;
      mem_din_o  = ld_data_q;
    end
    cpu_hold_o     = cpu_hold_q;
    ldr_overflow_o = ovf_q;
    fifo_level_o   = level_q;
  end

endmodule

// File: tb/tb_loader_port_sched.sv
// Bench for loader_port_sched: queue-based behavioural model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_loader_port_sched;
  localparam int AW = 22;

  logic          clk = 1'b0, reset = 1'b0;
  logic [1:0]    nes_ce = 2'd0;
  logic          downloading = 1'b0, ldr_wr = 1'b0;
  logic [AW-1:0] ldr_addr = '0, cpu_addr = '0;
  logic [7:0]    ldr_data = '0, cpu_dout = '0;
  logic          cpu_read = 1'b0, cpu_write = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_oe, cpu_hold, ldr_overflow;
  logic [7:0]    mem_din;
  logic [2:0]    fifo_level;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  loader_port_sched dut (
    .clk_i(clk), .reset_i(reset), .nes_ce_i(nes_ce), .downloading_i(downloading),
    .ldr_wr_i(ldr_wr), .ldr_addr_i(ldr_addr), .ldr_data_i(ldr_data),
    .cpu_addr_i(cpu_addr), .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
    .cpu_dout_i(cpu_dout), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_oe_o(mem_oe), .mem_din_o(mem_din), .cpu_hold_o(cpu_hold),
    .ldr_overflow_o(ldr_overflow), .fifo_level_o(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } ent_t;
  typedef enum int {M_BOOT, M_LOAD, M_DRAIN, M_HOLD, M_IDLE} mmode_t;

  mmode_t        m_mode = M_BOOT;
  ent_t          m_q[$];
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = '0;
  bit            m_ovf = 1'b0, m_prev_dl = 1'b0;
  int            m_hold_left = 0;

  task automatic model_step();
    bit     slot, writer, listening, pop, take, lost;
    mmode_t nxt;
    ent_t   h;
    slot      = (nes_ce == 2'd1);
    writer    = (m_mode == M_LOAD) || (m_mode == M_DRAIN);
    listening = writer || (m_mode == M_HOLD);
    pop       = writer && slot && (m_q.size() > 0);
    take      = ldr_wr && listening && ((m_q.size() < 4) || pop);
    lost      = ldr_wr && listening && !take;
    nxt       = m_mode;
    case (m_mode)
      M_BOOT, M_IDLE: if (downloading) nxt = M_LOAD;
      M_LOAD:         if (!downloading) nxt = M_DRAIN;
      M_DRAIN: begin
        if (downloading) nxt = M_LOAD;
        else if (m_q.size() == 0 && !m_we) begin nxt = M_HOLD; m_hold_left = 255; end
      end
      M_HOLD: begin
        if (downloading) nxt = M_LOAD;
        else begin
          m_hold_left--;
          if (m_hold_left == 0) nxt = M_IDLE;
        end
      end
      default: nxt = M_BOOT;
    endcase
    if (pop) begin
      h = m_q.pop_front();
      m_we = 1'b1; m_addr = h.a; m_data = h.d;
    end else if (slot) begin
      m_we = 1'b0;
    end
    if (take) begin
      h = {ldr_addr, ldr_data};
      m_q.push_back(h);
    end
    if (downloading && !m_prev_dl) m_ovf = 1'b0;
    if (lost) m_ovf = 1'b1;
    m_prev_dl = downloading;
    m_mode = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_mode = M_BOOT; m_q.delete(); m_we = 1'b0; m_addr = '0; m_data = '0;
        m_ovf = 1'b0; m_prev_dl = 1'b0; m_hold_left = 0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [AW-1:0] e_addr;
    logic [7:0]    e_din;
    logic          e_we, e_oe;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (m_mode == M_IDLE) begin
          e_addr = cpu_addr; e_we = cpu_write; e_oe = cpu_read; e_din = cpu_dout;
        end else begin
          e_addr = m_addr; e_we = m_we; e_oe = 1'b0; e_din = m_data;
        end
        check("cycle{addr,we,oe,din,hold,ovf,lvl}",
              {27'd0, mem_addr, mem_we, mem_oe, mem_din, cpu_hold, ldr_overflow, fifo_level},
              {27'd0, e_addr, e_we, e_oe, e_din, m_mode != M_IDLE, m_ovf, 3'(m_q.size())});
      end
    end
  end

  // Records each mem_we pulse: address/data at its start, length at its end.
  logic [29:0] rise_q[$];
  int          len_q[$];
  initial begin
    int   run_len = 0;
    logic we_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_we && !we_prev) begin
        rise_q.push_back({mem_addr, mem_din});
        run_len = 1;
      end else if (mem_we) begin
        run_len++;
      end else if (we_prev) begin
        len_q.push_back(run_len);
      end
      we_prev = mem_we;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1 nes_ce = nes_ce + 2'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
    ldr_addr = a; ldr_data = d; ldr_wr = 1'b1;
    tick();
    ldr_wr = 1'b0;
  endtask

  task automatic align(input logic [1:0] ph);
    for (int i = 0; i < 4 && nes_ce != ph; i++) tick();
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (!(fifo_level == 3'd0 && mem_we == 1'b0) && k < 200) begin tick(); k++; end
    check(name, k < 200, 1);
  endtask

  initial begin
    int          n;
    logic [29:0] exp_ent;

    #3 reset = 1'b1;
    #1 chk_en = 1'b1;
    ticks(3);
    reset = 1'b0;

    // 1: BOOT holds the CPU, blocks its strobes and ignores loader writes.
    cpu_addr = 22'h123; cpu_read = 1'b1; cpu_write = 1'b1; ldr_wr = 1'b1;
    ticks(3);
    ldr_wr = 1'b0;
    check("t1_cpu_hold", cpu_hold, 1);
    check("t1_mem_we", mem_we, 0);
    check("t1_mem_oe", mem_oe, 0);
    check("t1_fifo_level", fifo_level, 0);
    cpu_read = 1'b0; cpu_write = 1'b0;

    // 2: 16 spaced bytes produce 16 in-order 4-clk write pulses.
    downloading = 1'b1;
    ticks(2);
    rise_q.delete(); len_q.delete();
    for (int i = 0; i < 16; i++) begin
      push(22'(i), 8'hA0 + 8'(i));
      ticks(7);
    end
    ticks(8);
    check("t2_pulse_count", rise_q.size(), 16);
    check("t2_len_count", len_q.size(), 16);
    for (int i = 0; i < 16 && i < rise_q.size() && i < len_q.size(); i++) begin
      exp_ent = {22'(i), 8'hA0 + 8'(i)};
      check($sformatf("t2_write%0d_addr_data", i), rise_q[i], exp_ent);
      check($sformatf("t2_write%0d_len", i), len_q[i], 4);
    end
    check("t2_overflow", ldr_overflow, 0);

    // 3: 6-byte burst starting on a slot clk: 5 accepted, 6th dropped.
    align(2'd1);
    for (int j = 0; j < 6; j++) begin
      ldr_addr = 22'(100 + j); ldr_data = 8'(8'h10 + j); ldr_wr = 1'b1;
      tick();
    end
    ldr_wr = 1'b0;
    check("t3_level_full", fifo_level, 4);
    check("t3_overflow_set", ldr_overflow, 1);
    downloading = 1'b0; tick();
    downloading = 1'b1; tick();
    check("t3_overflow_cleared", ldr_overflow, 0);
    wait_drain("t3_drain_timeout");

    // 4: downloading drops with 3 queued; hold lasts 1 DRAIN clk + 255 HOLD clk.
    align(2'd1);
    ldr_wr = 1'b1;
    for (int j = 0; j < 4; j++) begin
      ldr_addr = 22'(200 + j); ldr_data = 8'(8'h50 + j);
      tick();
    end
    ldr_wr = 1'b0; downloading = 1'b0;
    tick();
    check("t4_queued", fifo_level, 3);
    check("t4_hold_during_drain", cpu_hold, 1);
    wait_drain("t4_drain_timeout");
    n = 0;
    while (cpu_hold && n < 1000) begin n++; tick(); end
    check("t4_hold_cycles", n, 256);
    cpu_addr = 22'h8000; cpu_read = 1'b1;
    #1;
    check("t4_cpu_addr_pass", mem_addr, 22'h8000);
    check("t4_cpu_oe_pass", mem_oe, 1);
    tick();
    cpu_read = 1'b0;

    // 5: new download during HOLD at count 100 returns to LOAD with the CPU held.
    downloading = 1'b1; tick();
    push(22'h1234, 8'h77);
    downloading = 1'b0;
    wait_drain("t5_drain_timeout");
    ticks(155);
    check("t5_hold_in_hold", cpu_hold, 1);
    downloading = 1'b1;
    tick();
    check("t5_hold_after_reload", cpu_hold, 1);
    rise_q.delete();
    push(22'd300, 8'h66);
    ticks(7);
    push(22'd301, 8'h67);
    ticks(10);
    check("t5_new_writes", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      check("t5_first_write", rise_q[0], {22'd300, 8'h66});
      check("t5_second_write", rise_q[1], {22'd301, 8'h67});
    end
    check("t5_hold_still", cpu_hold, 1);

    // 6: async reset while a write is in flight with 2 more queued.
    align(2'd2);
    ldr_wr = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ldr_addr = 22'(500 + j); ldr_data = 8'(8'hC0 + j);
      tick();
    end
    ldr_wr = 1'b0;
    tick();
    check("t6_we_before_reset", mem_we, 1);
    check("t6_level_before_reset", fifo_level, 2);
    #3 reset = 1'b1;
    #1;
    check("t6_we_async_drop", mem_we, 0);
    check("t6_level_flushed", fifo_level, 0);
    check("t6_hold_reset", cpu_hold, 1);
    downloading = 1'b0;
    ticks(2);
    reset = 1'b0;
    cpu_read = 1'b1; cpu_write = 1'b1;
    push(22'd600, 8'h01);
    check("t6_boot_ignores_ldr", fifo_level, 0);
    check("t6_boot_blocks_oe", mem_oe, 0);
    check("t6_boot_blocks_we", mem_we, 0);
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
